id_ex_alu_issue: RTL and testbench
==================================

// Module: id_ex_alu_issue
// PURPOSE
//  ID->EX pipeline stage of the RV32I core; feeds the execute-stage ALU directly.
//  Decodes opcode/funct3/funct7 into the 4-bit ALU operator and selects operands (rs1/pc/0, rs2/imm/4).
//  Applies MEM/WB forwarding and registers everything for one cycle under a valid/ready handshake.
//  Supports stall (downstream backpressure) and flush (branch/jump redirect).
// PARAMETERS
//  D_WIDTH  32  datapath width (RV32I: fixed at 32)
//  OP_W     4   ALU operator width
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   synchronous active-low reset
//  flush        in   1   kill EX contents and any ID capture this cycle
//  id_valid     in   1   ID holds an instruction
//  id_ready     out  1   stage accepts this cycle (comb)
//  id_instr     in   32  raw instruction word
//  id_pc        in   32  instruction PC
//  id_rs1_data  in   32  regfile read port 1
//  id_rs2_data  in   32  regfile read port 2
//  fwd_mem_we/fwd_wb_we  in 1; fwd_mem_rd/fwd_wb_rd in 5; fwd_mem_data/fwd_wb_data in 32  forwarding buses
//  ex_valid     out  1   EX register holds a live instruction
//  ex_ready     in   1   ALU/next stage consumes EX contents this cycle
//  ex_alu_op    out  4   0000 add,0001 sub,0010 sll,0011 slt,0100 sltu,0101 xor,0110 srl,0111 sra,1000 or,1001 and
//  ex_alu_a     out  32  ALU operand a
//  ex_alu_b     out  32  ALU operand b
//  ex_rs2_val   out  32  forwarded rs2 (store data / branch compare)
//  ex_rd        out  5   destination register
//  ex_rd_we     out  1   writeback enable
//  ex_illegal   out  1   unsupported opcode captured
// BEHAVIOUR
//  Reset (rst_n=0 at edge): every registered output = 0 (ex_alu_op=add); overrides flush and capture.
//  id_ready = !ex_valid || ex_ready. Capture when id_valid && id_ready && !flush; latency 1 cycle.
//  Next ex_valid: flush->0; else capture->1; else if ex_ready->0; else hold.
//  Hold (ex_valid && !ex_ready): all fields stable except operands sourced from rs1/rs2,
//   which are refreshed from forwarding buses on match (stored rs1/rs2 indices + select flags).
//  Forwarding per source reg r: r==0 -> 0; fwd_mem_we && fwd_mem_rd==r -> mem data;
//   else fwd_wb_we && fwd_wb_rd==r -> wb data; else regfile data. MEM beats WB.
//  Decode (opcode -> a, b, op, rd_we):
//   OP 0110011: rs1, rs2; funct3 000 add/sub(funct7[5]),001 sll,010 slt,011 sltu,100 xor,
//    101 srl/sra(funct7[5]),110 or,111 and; rd_we=1
//   OP-IMM 0010011: rs1, I-imm sign-ext; same map, 000 never sub, 101 sra iff instr[30]
//   Shifts (both): b = {27'b0, shamt[4:0]} (rs2[4:0] or instr[24:20]); ALU sees no upper bits.
//   LOAD 0000011: rs1+I-imm, add, rd_we=1.  STORE 0100011: rs1+S-imm, add, rd_we=0
//   LUI 0110111: 0+U-imm, add.  AUIPC 0010111: pc+U-imm, add.  JAL/JALR: pc+4, add, rd_we=1
//   BRANCH 1100011: rs1, rs2; BEQ/BNE sub, BLT/BGE slt, BLTU/BGEU sltu; rd_we=0
//   Other opcode: ex_illegal=1, op add, a=b=0, rd_we=0 (still flows with ex_valid=1)
//  ex_rd_we forced 0 when rd==0. ex_rd = instr[11:7] (0 when rd_we not applicable).
//  Flush and capture same cycle: flush wins, instruction dropped; id_ready stays comb as above.
// TESTING
//  ADD x3,x1,x2 rs1=5 rs2=7, ex_ready=1 -> next cycle ex_valid=1 op=0000 a=5 b=7 rd=3 we=1
//  SUB with fwd_mem rd=1 data=0x10 and fwd_wb rd=1 data=0x20, rs2=4 -> a=0x10 b=4 op=0001
//  SRAI x5,x6,3 / SLL rs2=0xFFFFFF21 -> op=0111 b=3 / op=0010 b=1
//  ex_ready=0 for 3 cycles, new ID instr pending -> id_ready=0, EX fields held; WB fwd
//   to held rs1 updates ex_alu_a; ex_ready=1 -> pending instr captured next cycle
//  flush with id_valid=1 -> ex_valid=0 next cycle; rst_n=0 mid-stall -> all outputs 0
//  JAL pc=0x100 rd=x0 -> a=0x100 b=4 op=add we=0; opcode 1111111 -> ex_illegal=1 we=0

Source files
------------

// File: rtl/id_ex_alu_issue_if.sv
// ID->EX issue bus: instruction/operand capture, forwarding buses, and
// the EX-side register outputs that feed the ALU directly.
interface id_ex_alu_issue_if #(
    parameter int D_WIDTH = 32,
    parameter int OP_W    = 4
);
    // ID side
    logic               flush;
    logic               id_valid;
    logic               id_ready;
    logic [31:0]        id_instr;
    logic [D_WIDTH-1:0] id_pc;
    logic [D_WIDTH-1:0] id_rs1_data;
    logic [D_WIDTH-1:0] id_rs2_data;

    // forwarding buses (MEM has priority over WB)
    logic               fwd_mem_we;
    logic [4:0]         fwd_mem_rd;
    logic [D_WIDTH-1:0] fwd_mem_data;
    logic               fwd_wb_we;
    logic [4:0]         fwd_wb_rd;
    logic [D_WIDTH-1:0] fwd_wb_data;

    // EX side
    logic               ex_valid;
    logic               ex_ready;
    logic [OP_W-1:0]    ex_alu_op;
    logic [D_WIDTH-1:0] ex_alu_a;
    logic [D_WIDTH-1:0] ex_alu_b;
    logic [D_WIDTH-1:0] ex_rs2_val;
    logic [4:0]         ex_rd;
    logic               ex_rd_we;
    logic               ex_illegal;

    // driver of the stage: decode/regfile/forward sources and the EX consumer
    modport master (
        output flush, id_valid, id_instr, id_pc, id_rs1_data, id_rs2_data,
        output fwd_mem_we, fwd_mem_rd, fwd_mem_data,
        output fwd_wb_we, fwd_wb_rd, fwd_wb_data,
        output ex_ready,
        input  id_ready,
        input  ex_valid, ex_alu_op, ex_alu_a, ex_alu_b, ex_rs2_val,
        input  ex_rd, ex_rd_we, ex_illegal
    );

    // the pipeline stage itself
    modport slave (
        input  flush, id_valid, id_instr, id_pc, id_rs1_data, id_rs2_data,
        input  fwd_mem_we, fwd_mem_rd, fwd_mem_data,
        input  fwd_wb_we, fwd_wb_rd, fwd_wb_data,
        input  ex_ready,
        output id_ready,
        output ex_valid, ex_alu_op, ex_alu_a, ex_alu_b, ex_rs2_val,
        output ex_rd, ex_rd_we, ex_illegal
    );
endinterface

// File: rtl/id_ex_alu_issue.sv
// ID->EX pipeline register for the RV32I core. Decodes the ALU operator,
// selects forwarded operands, and holds one instruction under valid/ready.
// While stalled, operands that came from rs1/rs2 keep tracking the forwarding
// buses so a producer retiring during the stall is not lost.
module id_ex_alu_issue #(
    parameter int D_WIDTH = 32,
    parameter int OP_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_alu_issue_if.slave   bus
);

    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b0100;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b1000;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [D_WIDTH-1:0] ZERO_W = {D_WIDTH{1'b0}};
    localparam logic [D_WIDTH-1:0] FOUR_W = {{(D_WIDTH-3){1'b0}}, 3'b100};

    // ------------------------------------------------------------------
    // helpers
    // ------------------------------------------------------------------

    // Operand value for source register idx at capture time.
    function automatic logic [D_WIDTH-1:0] fwd_sel(
        input logic [4:0]         idx,
        input logic [D_WIDTH-1:0] rf_data,
        input logic               mem_we,
        input logic [4:0]         mem_rd,
        input logic [D_WIDTH-1:0] mem_data,
        input logic               wb_we,
        input logic [4:0]         wb_rd,
        input logic [D_WIDTH-1:0] wb_data
    );
        logic [D_WIDTH-1:0] res;
        if (idx == 5'd0) begin
            res = ZERO_W;
        end else if (mem_we && (mem_rd == idx)) begin
            res = mem_data;
        end else if (wb_we && (wb_rd == idx)) begin
            res = wb_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    // Operand value while held: only a forwarding hit replaces it.
    function automatic logic [D_WIDTH-1:0] fwd_refresh(
        input logic [4:0]         idx,
        input logic [D_WIDTH-1:0] cur,
        input logic               mem_we,
        input logic [4:0]         mem_rd,
        input logic [D_WIDTH-1:0] mem_data,
        input logic               wb_we,
        input logic [4:0]         wb_rd,
        input logic [D_WIDTH-1:0] wb_data
    );
        logic [D_WIDTH-1:0] res;
        if (idx == 5'd0) begin
            res = cur;
        end else if (mem_we && (mem_rd == idx)) begin
            res = mem_data;
        end else if (wb_we && (wb_rd == idx)) begin
            res = wb_data;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // funct3 -> ALU operator; alt selects sub (000) or sra (101).
    function automatic logic [OP_W-1:0] alu_map(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [OP_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Shift amount zero-extended so the ALU never sees upper bits.
    function automatic logic [D_WIDTH-1:0] shamt_ext(input logic [D_WIDTH-1:0] v);
        return {{(D_WIDTH-5){1'b0}}, v[4:0]};
    endfunction

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    logic               r_ex_valid;
    logic [OP_W-1:0]    r_alu_op;
    logic [D_WIDTH-1:0] r_alu_a;
    logic [D_WIDTH-1:0] r_alu_b;
    logic [D_WIDTH-1:0] r_rs2_val;
    logic [4:0]         r_rd;
    logic               r_rd_we;
    logic               r_illegal;
    logic [4:0]         r_rs1_idx;
    logic [4:0]         r_rs2_idx;
    logic               r_a_rs1;
    logic               r_b_rs2;
    logic               r_b_sh;
    logic               r_rs2_used;

    // ------------------------------------------------------------------
    // decode
    // ------------------------------------------------------------------
    logic [31:0]        w_instr;
    logic [6:0]         w_opc;
    logic [2:0]         w_f3;
    logic [4:0]         w_rd_f;
    logic [4:0]         w_rs1_f;
    logic [4:0]         w_rs2_f;
    logic [D_WIDTH-1:0] w_imm_i;
    logic [D_WIDTH-1:0] w_imm_s;
    logic [D_WIDTH-1:0] w_imm_u;
    logic [D_WIDTH-1:0] w_rs1_fwd;
    logic [D_WIDTH-1:0] w_rs2_fwd;
    logic               w_is_shift;

    logic [OP_W-1:0]    w_op;
    logic [D_WIDTH-1:0] w_a;
    logic [D_WIDTH-1:0] w_b;
    logic [D_WIDTH-1:0] w_rs2_val;
    logic               w_rd_we;
    logic               w_illegal;
    logic               w_a_rs1;
    logic               w_b_rs2;
    logic               w_b_sh;
    logic               w_rs2_used;
    logic [4:0]         w_rd;
    logic               w_rd_we_eff;

    logic               w_capture;
    logic               w_hold;
    logic [D_WIDTH-1:0] w_hold_a;
    logic [D_WIDTH-1:0] w_hold_b_raw;
    logic [D_WIDTH-1:0] w_hold_b;
    logic [D_WIDTH-1:0] w_hold_rs2;

    assign w_instr    = bus.id_instr;
    assign w_opc      = w_instr[6:0];
    assign w_f3       = w_instr[14:12];
    assign w_rd_f     = w_instr[11:7];
    assign w_rs1_f    = w_instr[19:15];
    assign w_rs2_f    = w_instr[24:20];
    assign w_imm_i    = {{(D_WIDTH-12){w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s    = {{(D_WIDTH-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_u    = {w_instr[31:12], 12'h000};
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    assign w_rs1_fwd = fwd_sel(w_rs1_f, bus.id_rs1_data,
                               bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                               bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data);
    assign w_rs2_fwd = fwd_sel(w_rs2_f, bus.id_rs2_data,
                               bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                               bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data);

    // Opcode decode: ALU operator, operand sources and writeback intent.
    always_comb begin
        w_op       = ALU_ADD;
        w_a        = ZERO_W;
        w_b        = ZERO_W;
        w_rs2_val  = ZERO_W;
        w_rd_we    = 1'b0;
        w_illegal  = 1'b0;
        w_a_rs1    = 1'b0;
        w_b_rs2    = 1'b0;
        w_b_sh     = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_op       = alu_map(w_f3, w_instr[30]);
                w_a        = w_rs1_fwd;
                w_b        = w_is_shift ? shamt_ext(w_rs2_fwd) : w_rs2_fwd;
                w_rs2_val  = w_rs2_fwd;
                w_rd_we    = 1'b1;
                w_a_rs1    = 1'b1;
                w_b_rs2    = 1'b1;
                w_b_sh     = w_is_shift;
                w_rs2_used = 1'b1;
            end
            OPC_OP_IMM: begin
                // addi never subtracts; instr[30] only selects srai
                w_op    = alu_map(w_f3, (w_f3 == 3'b101) && w_instr[30]);
                w_a     = w_rs1_fwd;
                w_b     = w_is_shift ? shamt_ext(w_imm_i) : w_imm_i;
                w_rd_we = 1'b1;
                w_a_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                w_a     = w_rs1_fwd;
                w_b     = w_imm_i;
                w_rd_we = 1'b1;
                w_a_rs1 = 1'b1;
            end
            OPC_STORE: begin
                w_a        = w_rs1_fwd;
                w_b        = w_imm_s;
                w_rs2_val  = w_rs2_fwd;
                w_a_rs1    = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_LUI: begin
                w_b     = w_imm_u;
                w_rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                w_a     = bus.id_pc;
                w_b     = w_imm_u;
                w_rd_we = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // link value pc+4; the target is computed elsewhere
                w_a     = bus.id_pc;
                w_b     = FOUR_W;
                w_rd_we = 1'b1;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    3'b100, 3'b101: w_op = ALU_SLT;
                    3'b110, 3'b111: w_op = ALU_SLTU;
                    default:        w_op = ALU_SUB;
                endcase
                w_a        = w_rs1_fwd;
                w_b        = w_rs2_fwd;
                w_rs2_val  = w_rs2_fwd;
                w_a_rs1    = 1'b1;
                w_b_rs2    = 1'b1;
                w_rs2_used = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_rd        = w_rd_we ? w_rd_f : 5'd0;
    assign w_rd_we_eff = w_rd_we && (w_rd_f != 5'd0);

    // ------------------------------------------------------------------
    // handshake and hold-time operand refresh
    // ------------------------------------------------------------------
    assign bus.id_ready = !r_ex_valid || bus.ex_ready;
    assign w_capture    = bus.id_valid && bus.id_ready && !bus.flush;
    assign w_hold       = r_ex_valid && !bus.ex_ready;

    assign w_hold_a = r_a_rs1 ?
        fwd_refresh(r_rs1_idx, r_alu_a,
                    bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                    bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data) : r_alu_a;
    assign w_hold_b_raw = r_b_rs2 ?
        fwd_refresh(r_rs2_idx, r_alu_b,
                    bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                    bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data) : r_alu_b;
    assign w_hold_b = r_b_sh ? shamt_ext(w_hold_b_raw) : w_hold_b_raw;
    assign w_hold_rs2 = r_rs2_used ?
        fwd_refresh(r_rs2_idx, r_rs2_val,
                    bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                    bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data) : r_rs2_val;

    // EX register: reset, flush, capture, stall refresh, or drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_alu_op   <= ALU_ADD;
            r_alu_a    <= ZERO_W;
            r_alu_b    <= ZERO_W;
            r_rs2_val  <= ZERO_W;
            r_rd       <= 5'd0;
            r_rd_we    <= 1'b0;
            r_illegal  <= 1'b0;
            r_rs1_idx  <= 5'd0;
            r_rs2_idx  <= 5'd0;
            r_a_rs1    <= 1'b0;
            r_b_rs2    <= 1'b0;
            r_b_sh     <= 1'b0;
            r_rs2_used <= 1'b0;
        end else if (bus.flush) begin
            // redirect: kill whatever EX holds and drop any ID capture
            r_ex_valid <= 1'b0;
            r_rd_we    <= 1'b0;
        end else if (w_capture) begin
            r_ex_valid <= 1'b1;
            r_alu_op   <= w_op;
            r_alu_a    <= w_a;
            r_alu_b    <= w_b;
            r_rs2_val  <= w_rs2_val;
            r_rd       <= w_rd;
            r_rd_we    <= w_rd_we_eff;
            r_illegal  <= w_illegal;
            r_rs1_idx  <= w_rs1_f;
            r_rs2_idx  <= w_rs2_f;
            r_a_rs1    <= w_a_rs1;
            r_b_rs2    <= w_b_rs2;
            r_b_sh     <= w_b_sh;
            r_rs2_used <= w_rs2_used;
        end else if (w_hold) begin
            r_alu_a    <= w_hold_a;
            r_alu_b    <= w_hold_b;
            r_rs2_val  <= w_hold_rs2;
        end else if (bus.ex_ready) begin
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_valid <= r_ex_valid;
        end
    end

    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_alu_op  = r_alu_op;
    assign bus.ex_alu_a   = r_alu_a;
    assign bus.ex_alu_b   = r_alu_b;
    assign bus.ex_rs2_val = r_rs2_val;
    assign bus.ex_rd      = r_rd;
    assign bus.ex_rd_we   = r_rd_we;
    assign bus.ex_illegal = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: hand-computed expectations for decode,
// forwarding priority, stall hold/refresh, flush and reset.
module tb_id_ex_alu_issue;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    id_ex_alu_issue_if bus_if ();

    id_ex_alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mdat,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wdat);
        bus_if.fwd_mem_we   = mwe;
        bus_if.fwd_mem_rd   = mrd;
        bus_if.fwd_mem_data = mdat;
        bus_if.fwd_wb_we    = wwe;
        bus_if.fwd_wb_rd    = wrd;
        bus_if.fwd_wb_data  = wdat;
    endtask

    // present one instruction with ex_ready=1 and let it be captured
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus_if.id_instr    = instr;
        bus_if.id_pc       = pc;
        bus_if.id_rs1_data = rs1;
        bus_if.id_rs2_data = rs2;
        bus_if.id_valid    = 1'b1;
        bus_if.ex_ready    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.id_valid    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.flush       = 1'b0;
        bus_if.id_valid    = 1'b0;
        bus_if.id_instr    = 32'h0000_0000;
        bus_if.id_pc       = 32'h0000_0000;
        bus_if.id_rs1_data = 32'h0000_0000;
        bus_if.id_rs2_data = 32'h0000_0000;
        bus_if.ex_ready    = 1'b1;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus_if.ex_valid}, 32'd0);
        chk("rst_op",    {28'd0, bus_if.ex_alu_op}, 32'd0);
        chk("rst_a",     bus_if.ex_alu_a, 32'd0);
        chk("rst_b",     bus_if.ex_alu_b, 32'd0);
        chk("rst_rd",    {27'd0, bus_if.ex_rd}, 32'd0);
        chk("rst_we",    {31'd0, bus_if.ex_rd_we}, 32'd0);
        chk("rst_ill",   {31'd0, bus_if.ex_illegal}, 32'd0);
        chk("rst_ready", {31'd0, bus_if.id_ready}, 32'd1);
        rst_n = 1'b1;

        // ADD x3,x1,x2
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP), 32'h0, 32'd5, 32'd7);
        chk("add_valid", {31'd0, bus_if.ex_valid}, 32'd1);
        chk("add_op",    {28'd0, bus_if.ex_alu_op}, 32'h0);
        chk("add_a",     bus_if.ex_alu_a, 32'd5);
        chk("add_b",     bus_if.ex_alu_b, 32'd7);
        chk("add_rd",    {27'd0, bus_if.ex_rd}, 32'd3);
        chk("add_we",    {31'd0, bus_if.ex_rd_we}, 32'd1);
        chk("add_rs2v",  bus_if.ex_rs2_val, 32'd7);

        // SUB x4,x1,x2: MEM and WB both hit x1, MEM wins
        set_fwd(1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20);
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, OP), 32'h0, 32'd5, 32'd4);
        chk("sub_op", {28'd0, bus_if.ex_alu_op}, 32'h1);
        chk("sub_a",  bus_if.ex_alu_a, 32'h10);
        chk("sub_b",  bus_if.ex_alu_b, 32'd4);

        // same SUB, only WB hits x2
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd2, 32'h20);
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, OP), 32'h0, 32'd5, 32'd4);
        chk("wbfwd_a", bus_if.ex_alu_a, 32'd5);
        chk("wbfwd_b", bus_if.ex_alu_b, 32'h20);

        // ADD x1,x0,x2: x0 reads zero even with regfile and MEM noise
        set_fwd(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
        issue(enc_r(7'h00, 5'd2, 5'd0, 3'b000, 5'd1, OP), 32'h0, 32'h55, 32'd9);
        chk("x0_a", bus_if.ex_alu_a, 32'd0);
        chk("x0_b", bus_if.ex_alu_b, 32'd9);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // SRAI x5,x6,3
        issue(enc_i(12'h403, 5'd6, 3'b101, 5'd5, OPI), 32'h0, 32'h80, 32'h0);
        chk("srai_op", {28'd0, bus_if.ex_alu_op}, 32'h7);
        chk("srai_a",  bus_if.ex_alu_a, 32'h80);
        chk("srai_b",  bus_if.ex_alu_b, 32'd3);

        // SLL x7,x8,x9 with rs2=0xFFFFFF21: only shamt reaches b
        issue(enc_r(7'h00, 5'd9, 5'd8, 3'b001, 5'd7, OP), 32'h0, 32'd1, 32'hFFFF_FF21);
        chk("sll_op",   {28'd0, bus_if.ex_alu_op}, 32'h2);
        chk("sll_b",    bus_if.ex_alu_b, 32'd1);
        chk("sll_rs2v", bus_if.ex_rs2_val, 32'hFFFF_FF21);

        // ADDI x1,x2,-1: sign extension, never sub
        issue(enc_i(12'hFFF, 5'd2, 3'b000, 5'd1, OPI), 32'h0, 32'h10, 32'h0);
        chk("addi_op", {28'd0, bus_if.ex_alu_op}, 32'h0);
        chk("addi_b",  bus_if.ex_alu_b, 32'hFFFF_FFFF);

        // SW x2,-4(x1)
        issue({7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011}, 32'h0, 32'h1000, 32'hDEAD);
        chk("sw_a",    bus_if.ex_alu_a, 32'h1000);
        chk("sw_b",    bus_if.ex_alu_b, 32'hFFFF_FFFC);
        chk("sw_we",   {31'd0, bus_if.ex_rd_we}, 32'd0);
        chk("sw_rd",   {27'd0, bus_if.ex_rd}, 32'd0);
        chk("sw_rs2v", bus_if.ex_rs2_val, 32'hDEAD);

        // BLT / BGEU
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd0, BR), 32'h0, 32'd7, 32'd9);
        chk("blt_op", {28'd0, bus_if.ex_alu_op}, 32'h3);
        chk("blt_b",  bus_if.ex_alu_b, 32'd9);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd0, BR), 32'h0, 32'd7, 32'd9);
        chk("bgeu_op", {28'd0, bus_if.ex_alu_op}, 32'h4);
        chk("bgeu_we", {31'd0, bus_if.ex_rd_we}, 32'd0);

        // LUI x1,0x12345
        issue({20'h12345, 5'd1, 7'b0110111}, 32'h40, 32'h99, 32'h0);
        chk("lui_a", bus_if.ex_alu_a, 32'd0);
        chk("lui_b", bus_if.ex_alu_b, 32'h1234_5000);

        // JAL x0 at pc 0x100
        issue({20'h00000, 5'd0, 7'b1101111}, 32'h100, 32'h0, 32'h0);
        chk("jal_a",  bus_if.ex_alu_a, 32'h100);
        chk("jal_b",  bus_if.ex_alu_b, 32'd4);
        chk("jal_op", {28'd0, bus_if.ex_alu_op}, 32'h0);
        chk("jal_we", {31'd0, bus_if.ex_rd_we}, 32'd0);

        // unsupported opcode still flows
        issue({20'h00000, 5'd5, 7'b1111111}, 32'h0, 32'h33, 32'h44);
        chk("ill_flag",  {31'd0, bus_if.ex_illegal}, 32'd1);
        chk("ill_valid", {31'd0, bus_if.ex_valid}, 32'd1);
        chk("ill_we",    {31'd0, bus_if.ex_rd_we}, 32'd0);
        chk("ill_a",     bus_if.ex_alu_a, 32'd0);

        // stall: ADD x10,x12,x13 in EX, XOR x14,x15,x16 waits in ID
        issue(enc_r(7'h00, 5'd13, 5'd12, 3'b000, 5'd10, OP), 32'h0, 32'h11, 32'h22);
        chk("stl_ill_clr", {31'd0, bus_if.ex_illegal}, 32'd0);
        bus_if.id_instr    = enc_r(7'h00, 5'd16, 5'd15, 3'b100, 5'd14, OP);
        bus_if.id_rs1_data = 32'd3;
        bus_if.id_rs2_data = 32'd5;
        bus_if.id_valid    = 1'b1;
        bus_if.ex_ready    = 1'b0;
        #1;
        chk("stl_ready0", {31'd0, bus_if.id_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("stl1_a",  bus_if.ex_alu_a, 32'h11);
        chk("stl1_b",  bus_if.ex_alu_b, 32'h22);
        chk("stl1_rd", {27'd0, bus_if.ex_rd}, 32'd10);
        set_fwd(1'b1, 5'd13, 32'h44, 1'b1, 5'd12, 32'h99);
        @(posedge clk);
        #1;
        chk("stl2_a",    bus_if.ex_alu_a, 32'h99);
        chk("stl2_b",    bus_if.ex_alu_b, 32'h44);
        chk("stl2_rs2v", bus_if.ex_rs2_val, 32'h44);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("stl3_a",     bus_if.ex_alu_a, 32'h99);
        chk("stl3_valid", {31'd0, bus_if.ex_valid}, 32'd1);
        bus_if.ex_ready = 1'b1;
        #1;
        chk("stl_ready1", {31'd0, bus_if.id_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_if.id_valid = 1'b0;
        chk("xor_op", {28'd0, bus_if.ex_alu_op}, 32'h5);
        chk("xor_a",  bus_if.ex_alu_a, 32'd3);
        chk("xor_b",  bus_if.ex_alu_b, 32'd5);
        chk("xor_rd", {27'd0, bus_if.ex_rd}, 32'd14);

        // flush with a capture pending: flush wins
        bus_if.flush    = 1'b1;
        bus_if.id_valid = 1'b1;
        bus_if.id_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP);
        @(posedge clk);
        #1;
        bus_if.flush    = 1'b0;
        bus_if.id_valid = 1'b0;
        chk("flush_valid", {31'd0, bus_if.ex_valid}, 32'd0);

        // reset in the middle of a stall
        issue(enc_i(12'h005, 5'd0, 3'b000, 5'd2, OPI), 32'h0, 32'h0, 32'h0);
        chk("pre_b", bus_if.ex_alu_b, 32'd5);
        bus_if.ex_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_hold", {31'd0, bus_if.ex_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_valid", {31'd0, bus_if.ex_valid}, 32'd0);
        chk("mrst_b",     bus_if.ex_alu_b, 32'd0);
        chk("mrst_rd",    {27'd0, bus_if.ex_rd}, 32'd0);
        chk("mrst_we",    {31'd0, bus_if.ex_rd_we}, 32'd0);
        rst_n = 1'b1;
        bus_if.ex_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
